// File: rtl/wptr_full_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks: pointer width
// derivation and Gray/binary conversion helpers.
package wptr_full_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int PTR_W_DEF      = ADDR_WIDTH_DEF + 1;
    localparam int MAX_W          = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Helpers work on a wide zero-extended value; callers size-cast the result.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int unsigned i = MAX_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side FIFO control bundle: producer request/status and cross-domain pointers.
interface wptr_full_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  winc;
    logic                  clr_ovf;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;

    modport master (
        output winc, clr_ovf, rptr,
        input  wen, waddr, wptr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  winc, clr_ovf, rptr,
        output wen, waddr, wptr, full, almost_full, wlevel, overflow
    );

endinterface

// File: rtl/wptr_full_sync_ptr.sv
// Multi-flop synchronizer for a Gray pointer crossing into the local clock domain.
module sync_ptr #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/wptr_full.sv
// Write pointer and full/almost-full/level/overflow status for the dual-clock FIFO.
module wptr_full
    import wptr_full_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input logic        wclk,
    input logic        rst_n,
    wptr_full_if.slave bus
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int A     = ADDR_WIDTH;

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rptr_s;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_next;
    logic             accept;
    logic             full_next;

    sync_ptr #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_rptr (
        .clk   (wclk),
        .rst_n (rst_n),
        .din   (bus.rptr),
        .dout  (rptr_s)
    );

    assign accept     = bus.winc & ~bus.full;
    assign bus.wen    = accept;
    assign bus.waddr  = wbin[A-1:0];
    assign wbin_next  = wbin + PTR_W'(accept);
    assign wgray_next = PTR_W'(bin2gray(MAX_W'(wbin_next)));
    assign rbin_s     = PTR_W'(gray2bin(MAX_W'(rptr_s)));
    assign level_next = wbin_next - rbin_s;
    // Full when next write pointer is exactly one lap ahead of the synced read pointer.
    assign full_next  = (wgray_next == {~rptr_s[A:A-1], rptr_s[A-2:0]});

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin            <= '0;
            bus.wptr        <= '0;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.wlevel      <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            wbin            <= wbin_next;
            bus.wptr        <= wgray_next;
            bus.full        <= full_next;
            bus.almost_full <= (level_next >= PTR_W'(AFULL_THRESH));
            bus.wlevel      <= level_next;
            if (bus.winc && bus.full) begin
                bus.overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                bus.overflow <= 1'b0;
            end
        end
    end

endmodule
